// File: rtl/sfifo_pkg.sv
// Shared helpers for the single-clock FIFO: derived geometry and the
// elaboration-time legality rule for the parameter set.
package sfifo_pkg;

    // Number of storage entries for a given log2 depth.
    function automatic int calc_depth(input int fifo_size);
        return 1 << fifo_size;
    endfunction

    // Pointer width: storage address bits plus one wrap bit.
    function automatic int calc_ptr_w(input int fifo_size);
        return fifo_size + 1;
    endfunction

    // Parameter set is usable only with at least two entries' worth of
    // address bits, a positive data width and ordered thresholds.
    function automatic bit params_legal(input int data_width,
                                        input int fifo_size,
                                        input int afull_th,
                                        input int aempty_th);
        return (data_width >= 1) && (fifo_size >= 1) && (aempty_th >= 0) &&
               (aempty_th < afull_th) && (afull_th <= calc_depth(fifo_size));
    endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Storage array for sfifo: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset; occupancy is tracked by
// the pointers in the parent.
module sfifo_mem
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [calc_depth(ADDR_W)];

    // Write the accepted word into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, selectable FWFT or registered read, synchronous flush and
// sticky overflow/underflow flags.
module sfifo
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 8,
    parameter int AFULL_TH   = 2**FIFO_SIZE - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = 1
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  clr,
    input  logic                  enq,
    input  logic                  deq,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  aempty,
    output logic                  afull,
    output logic [FIFO_SIZE:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = calc_depth(FIFO_SIZE);
    localparam int PTR_W = calc_ptr_w(FIFO_SIZE);

    if (!params_legal(DATA_WIDTH, FIFO_SIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("sfifo: illegal parameters (need FIFO_SIZE>=1, AEMPTY_TH < AFULL_TH <= DEPTH)");
    end

    logic [PTR_W-1:0]      wp_q, wp_d;
    logic [PTR_W-1:0]      rp_q, rp_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    // Accept decisions use the registered flags only, so a read never frees
    // room for a same-cycle write and vice versa. Flags follow the next count.
    always_comb begin
        wr_acc  = enq && !full_q && !clr;
        rd_acc  = deq && !empty_q && !clr;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                wp_d = wp_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rp_d = rp_q + PTR_W'(1);
            end
            count_d = count_q + PTR_W'(wr_acc) - PTR_W'(rd_acc);
            if (enq && full_q) begin
                ovf_d = 1'b1;
            end
            if (deq && empty_q) begin
                unf_d = 1'b1;
            end
        end
        empty_d  = (count_d == '0);
        full_d   = (count_d == PTR_W'(DEPTH));
        aempty_d = (count_d <= PTR_W'(AEMPTY_TH));
        afull_d  = (count_d >= PTR_W'(AFULL_TH));
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sfifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (FIFO_SIZE)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (wr_acc),
        .waddr_i (wp_q[PTR_W-2:0]),
        .wdata_i (data_in),
        .raddr_i (rp_q[PTR_W-2:0]),
        .rdata_o (rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; a stale slot is masked while empty.
        assign data_out = empty_q ? '0 : rd_data;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;

        // Registered read: load the head word on an accepted read, else hold.
        always_ff @(posedge CLK or negedge RST_X) begin
            if (!RST_X) begin
                dout_q <= '0;
            end else if (clr) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign data_out = dout_q;
    end

    assign empty     = empty_q;
    assign full      = full_q;
    assign aempty    = aempty_q;
    assign afull     = afull_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_sfifo.sv
// Bench for sfifo: one FWFT and one registered-read instance share the same
// stimulus; a queue model predicts both and literal checks pin key points.
module tb_sfifo;

    localparam int DW = 8;
    localparam int FS = 2;
    localparam int DEPTH = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr = 1'b0;
    logic          enq = 1'b0;
    logic          deq = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] fw_dout, rg_dout;
    logic          fw_empty, fw_full, fw_aempty, fw_afull, fw_ovf, fw_unf;
    logic          rg_empty, rg_full, rg_aempty, rg_afull, rg_ovf, rg_unf;
    logic [FS:0]   fw_count, rg_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sfifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fw (
        .CLK(clk), .RST_X(rst_n), .clr(clr), .enq(enq), .deq(deq), .data_in(din),
        .data_out(fw_dout), .empty(fw_empty), .full(fw_full), .aempty(fw_aempty),
        .afull(fw_afull), .count(fw_count), .overflow(fw_ovf), .underflow(fw_unf)
    );

    sfifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_rg (
        .CLK(clk), .RST_X(rst_n), .clr(clr), .enq(enq), .deq(deq), .data_in(din),
        .data_out(rg_dout), .empty(rg_empty), .full(rg_full), .aempty(rg_aempty),
        .afull(rg_afull), .count(rg_count), .overflow(rg_ovf), .underflow(rg_unf)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rdout;
    bit            m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        bit was_full, was_empty;
        if (!rst_n) begin
            mq.delete();
            m_rdout = '0;
            m_ovf = 0;
            m_unf = 0;
        end else if (clr) begin
            mq.delete();
            m_rdout = '0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (enq && was_full) m_ovf = 1;
            if (deq && was_empty) m_unf = 1;
            if (deq && !was_empty) m_rdout = mq.pop_front();
            if (enq && !was_full) mq.push_back(din);
        end
    end

    task automatic cmp_dut(input string tag, input int cnt, input bit e, input bit f,
                           input bit ae, input bit af, input bit ov, input bit un,
                           input int d, input int exp_d);
        int n;
        n = mq.size();
        chk({tag, "_count"}, cnt, n);
        chk({tag, "_empty"}, int'(e), int'(n == 0));
        chk({tag, "_full"}, int'(f), int'(n == DEPTH));
        chk({tag, "_aempty"}, int'(ae), int'(n <= AE));
        chk({tag, "_afull"}, int'(af), int'(n >= AF));
        chk({tag, "_overflow"}, int'(ov), int'(m_ovf));
        chk({tag, "_underflow"}, int'(un), int'(m_unf));
        chk({tag, "_data"}, d, exp_d);
    endtask

    // Every falling edge: both instances against the model.
    always @(negedge clk) begin
        cmp_dut("fw", int'(fw_count), fw_empty, fw_full, fw_aempty, fw_afull, fw_ovf, fw_unf,
                int'(fw_dout), (mq.size() != 0) ? int'(mq[0]) : 0);
        cmp_dut("rg", int'(rg_count), rg_empty, rg_full, rg_aempty, rg_afull, rg_ovf, rg_unf,
                int'(rg_dout), int'(m_rdout));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input bit c, input bit e, input bit d, input logic [DW-1:0] v);
        clr = c;
        enq = e;
        deq = d;
        din = v;
        @(posedge clk);
        #1;
        clr = 0;
        enq = 0;
        deq = 0;
    endtask

    task automatic lit(input string nm, input int cnt, input bit ov, input bit un);
        chk({nm, "_fw_count"}, int'(fw_count), cnt);
        chk({nm, "_rg_count"}, int'(rg_count), cnt);
        chk({nm, "_fw_ovf"}, int'(fw_ovf), int'(ov));
        chk({nm, "_rg_ovf"}, int'(rg_ovf), int'(ov));
        chk({nm, "_fw_unf"}, int'(fw_unf), int'(un));
        chk({nm, "_rg_unf"}, int'(rg_unf), int'(un));
    endtask

    initial begin
        logic [DW-1:0] fill_v[4];
        logic [DW-1:0] seq[12];
        fill_v = '{8'h11, 8'h22, 8'h33, 8'h44};
        seq[0] = 8'hA0;
        seq[1] = 8'hA1;
        for (int i = 0; i < 10; i++) seq[i+2] = 8'hB0 + 8'(i);

        // Reset with clock running.
        #1 rst_n = 0;
        #22;
        lit("reset", 0, 0, 0);
        chk("reset_empty", int'(fw_empty & rg_empty), 1);
        chk("reset_aempty", int'(fw_aempty & rg_aempty), 1);
        chk("reset_full", int'(fw_full | rg_full), 0);
        chk("reset_afull", int'(fw_afull | rg_afull), 0);
        chk("reset_fw_data", int'(fw_dout), 0);
        chk("reset_rg_data", int'(rg_dout), 0);
        #4 rst_n = 1;
        @(posedge clk);
        #1;

        // Fill and overflow.
        step(0, 1, 0, 8'h11);
        lit("fill1", 1, 0, 0);
        chk("fill1_aempty", int'(fw_aempty), 1);
        chk("fill1_fw_data", int'(fw_dout), 'h11);
        step(0, 1, 0, 8'h22);
        lit("fill2", 2, 0, 0);
        chk("fill2_aempty", int'(fw_aempty), 0);
        chk("fill2_afull", int'(fw_afull), 0);
        step(0, 1, 0, 8'h33);
        lit("fill3", 3, 0, 0);
        chk("fill3_afull", int'(rg_afull), 1);
        chk("fill3_full", int'(rg_full), 0);
        step(0, 1, 0, 8'h44);
        lit("fill4", 4, 0, 0);
        chk("fill4_full", int'(fw_full & rg_full), 1);
        step(0, 1, 0, 8'h55);
        lit("ovf", 4, 1, 0);
        chk("ovf_fw_head", int'(fw_dout), 'h11);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_fw_data", i), int'(fw_dout), int'(fill_v[i]));
            step(0, 0, 1, 8'h00);
            chk($sformatf("drain%0d_rg_data", i), int'(rg_dout), int'(fill_v[i]));
            lit($sformatf("drain%0d", i), 3 - i, 1, 0);
        end
        chk("drained_empty", int'(fw_empty & rg_empty), 1);
        step(0, 0, 1, 8'h00);
        lit("unf", 0, 1, 1);
        chk("unf_rg_hold", int'(rg_dout), 'h44);
        chk("unf_fw_data", int'(fw_dout), 0);

        // Clear, then simultaneous enq/deq at count 2 across pointer wrap.
        step(1, 0, 0, 8'h00);
        lit("clr1", 0, 0, 0);
        chk("clr1_rg_data", int'(rg_dout), 0);
        step(0, 1, 0, seq[0]);
        step(0, 1, 0, seq[1]);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("sim%0d_fw_data", i), int'(fw_dout), int'(seq[i]));
            step(0, 1, 1, seq[i+2]);
            chk($sformatf("sim%0d_rg_data", i), int'(rg_dout), int'(seq[i]));
            lit($sformatf("sim%0d", i), 2, 0, 0);
            chk($sformatf("sim%0d_flags", i),
                int'({fw_empty, fw_full, fw_aempty, fw_afull}), 0);
        end
        step(0, 0, 1, 8'h00);
        chk("simtail0_rg_data", int'(rg_dout), int'(seq[10]));
        step(0, 0, 1, 8'h00);
        chk("simtail1_rg_data", int'(rg_dout), int'(seq[11]));
        lit("simtail", 0, 0, 0);

        // Full plus deq: write rejected, read accepted.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hC0 + 8'(i));
        step(0, 1, 1, 8'hC4);
        lit("fulldeq", 3, 1, 0);
        chk("fulldeq_rg_data", int'(rg_dout), 'hC0);
        chk("fulldeq_fw_data", int'(fw_dout), 'hC1);

        // Flush with a simultaneous enq.
        step(1, 1, 0, 8'hD0);
        lit("flush", 0, 0, 0);
        chk("flush_empty", int'(fw_empty & rg_empty), 1);
        chk("flush_fw_data", int'(fw_dout), 0);
        step(0, 1, 0, 8'hA5);
        chk("a5_fw_data", int'(fw_dout), 'hA5);
        step(0, 0, 1, 8'h00);
        chk("a5_rg_data", int'(rg_dout), 'hA5);
        lit("a5", 0, 0, 0);

        // Asynchronous reset mid-operation.
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h02);
        #2 rst_n = 0;
        #1;
        lit("midrst", 0, 0, 0);
        chk("midrst_empty", int'(fw_empty & rg_empty), 1);
        chk("midrst_aempty", int'(fw_aempty & rg_aempty), 1);
        chk("midrst_rg_data", int'(rg_dout), 0);
        chk("midrst_fw_data", int'(fw_dout), 0);
        @(negedge clk);
        rst_n = 1;
        step(0, 1, 0, 8'h77);
        lit("postrst", 1, 0, 0);
        chk("postrst_fw_data", int'(fw_dout), 'h77);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfifo.md
# sfifo

Single-clock, parametrised synchronous FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock domain. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through or registered read mode, a synchronous flush, and sticky overflow/underflow error flags. It sits between pipeline stages and DMA-style engines wherever buffering is needed without a clock crossing.

## Interface
- DATA_WIDTH, 32, entry width in bits.
- FIFO_SIZE, 8, log2 of the depth: DEPTH = 2**FIFO_SIZE; legal range is 1 or more.
- AFULL_TH, 2**FIFO_SIZE-2, afull asserts when count >= AFULL_TH; legal range is AEMPTY_TH < AFULL_TH <= DEPTH.
- AEMPTY_TH, 2, aempty asserts when count <= AEMPTY_TH.
- FWFT, 1, read mode: 1 = first-word-fall-through, 0 = registered read with 1-cycle latency.

- CLK  in  1  single clock, rising-edge.
- RST_X  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, highest priority.
- enq  in  1  write request.
- deq  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  count == 0; reset value 1.
- full  out  1  count == DEPTH; reset value 0.
- aempty  out  1  count <= AEMPTY_TH; reset value 1.
- afull  out  1  count >= AFULL_TH; reset value 0.
- count  out  FIFO_SIZE+1  current occupancy; reset value 0.
- overflow  out  1  sticky flag, set by enq while full; reset value 0.
- underflow  out  1  sticky flag, set by deq while empty; reset value 0.

## Operation
- Write and read pointers are binary, FIFO_SIZE+1 bits wide. Bits [FIFO_SIZE-1:0] address storage and the MSB is the wrap bit. Both pointers wrap naturally modulo 2*DEPTH.
- A write is accepted iff enq && !full. The write stores data_in at wp and increments wp.
- A read is accepted iff deq && !empty. The read increments rp.
- Full and empty are evaluated on the current registered state. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Next count = count + write_acc - read_acc. All flags are registered from the next count.
- overflow sets on enq && full. underflow sets on deq && empty. Each holds until clr or reset.
- clr takes priority over everything else in its cycle:
  - wp, rp and count go to 0.
  - Flags return to their reset values, and overflow/underflow clear.
  - enq and deq are ignored.
  - In FWFT=0 mode, data_out goes to 0.
  - Storage contents are not cleared.
- FWFT=1: data_out = mem[rp] when !empty, otherwise 0. The output is combinational from the registered rp and storage. deq acknowledges the word already shown.
- FWFT=0: data_out is a register with reset value 0. On an accepted read it loads mem[rp]. Otherwise it holds its value.

## Timing
- Asynchronous reset acts immediately on all registers. The first write is accepted at the first CLK edge with RST_X high.
- Write at edge N:
  - empty falls and count increments after edge N.
  - FWFT=1: the word is visible on data_out after edge N.
- FWFT=0: data_out updates after the edge of the accepted deq (latency 1).
- Simultaneous accepted write and read leaves count and all flags unchanged, and both pointers advance.
- Wrap-around: after 2*DEPTH writes, wp is back at 0 with no glitch in the flags.
- Reset asserted mid-operation discards all contents. Flags return to their reset values asynchronously.

## Structure
- Shared package/header holds the derived constants DEPTH and PTR_W = FIFO_SIZE+1, plus the elaboration-time parameter legality checks.
- Sub-module sfifo_mem holds the storage: 1-write/1-read, DEPTH x DATA_WIDTH array with synchronous write and asynchronous read.
- The top level holds the pointers, count, flag registers, the FWFT output mux, and the FWFT=0 output register.

## Test plan
All scenarios use FIFO_SIZE=2 (DEPTH=4), AFULL_TH=3, AEMPTY_TH=1, DATA_WIDTH=8.
- Reset:
  - Stimulus: RST_X low, with CLK toggling or stopped.
  - Required: empty=1, aempty=1, full=0, afull=0, count=0, overflow=0, underflow=0, data_out=0.
- Fill and overflow:
  - Stimulus: enq 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles.
  - Required: count goes 1→2→3→4; aempty falls at count 2; afull rises at count 3; full rises at count 4.
  - Required: 0x55 is dropped and overflow=1 and stays high.
- Drain order, FWFT=1 and FWFT=0:
  - Stimulus: deq continuously after the fill above.
  - Required: data_out sequence is 0x11, 0x22, 0x33, 0x44; empty rises after the 4th deq.
  - Required: one more deq sets underflow=1.
  - Required: FWFT=0 shows each word one cycle after its deq.
- Simultaneous enq/deq at count 2, held for 10 cycles:
  - Required: count stays 2 and flags are constant; output data order matches input order across pointer wrap.
- Full plus deq:
  - Stimulus: enq && deq while full.
  - Required: the write is rejected, overflow=1, count=3.
- Flush:
  - Stimulus: clr asserted at count 3 while overflow=1, with enq=1 in the same cycle.
  - Required: count=0, empty=1, overflow=0, and the enq is ignored.
  - Required: the next enq of 0xA5 is read back as 0xA5.
